// File: rtl/rotation_sequencer_pkg.sv
// Shared definitions for the rotation sequencer: FSM states, switch field
// positions and the speed-select to frame-period decode.
package rotation_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam int SW_WIDTH   = 18;
    localparam int ANGLE_W    = 7;
    localparam int AUTO_BIT   = 17;
    localparam int DIR_BIT    = 16;
    localparam int SPEED_MSB  = 15;
    localparam int SPEED_LSB  = 14;
    localparam int MANUAL_MSB = 6;
    localparam int MANUAL_LSB = 0;

    // Frames per auto step; kept 4 bits wide so it can be compared with fc+1.
    function automatic logic [3:0] speed_period(input logic [1:0] speed);
        logic [3:0] period;
        case (speed)
            2'd0:    period = 4'd1;
            2'd1:    period = 4'd2;
            2'd2:    period = 4'd4;
            default: period = 4'd8;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/rotation_sequencer_sw_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sw_sync #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rotation_sequencer.sv
// Frame-synchronous angle sequencer: picks the next rotation angle on each
// frame sync, drives the SIN/COS LUT address and strobes the coefficient load.
module rotation_sequencer
    import rotation_sequencer_pkg::*;
#(
    parameter int THETA_STEPS = 128,
    parameter int LUT_LATENCY = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [SW_WIDTH-1:0] iSW,
    input  logic                iFRAME_SYNC,
    output logic [ANGLE_W-1:0]  oLUT_ADDR,
    output logic [ANGLE_W-1:0]  oTHETA,
    output logic                oCOEF_LOAD,
    output logic                oBUSY,
    output logic                oMISSED
);

    localparam logic [ANGLE_W-1:0] MAX_IDX = ANGLE_W'(THETA_STEPS - 1);
    localparam logic [2:0]         LC_LAST = 3'(LUT_LATENCY - 1);

    logic [SW_WIDTH-1:0] swS;
    logic                unusedSwBits;

    state_e              state_q, state_d;
    logic [2:0]          lc_q, lc_d;
    logic [2:0]          fc_q, fc_d;
    logic [ANGLE_W-1:0]  lutAddr_q, lutAddr_d;
    logic [ANGLE_W-1:0]  theta_q, theta_d;
    logic                missed_q, missed_d;
    logic                autoPrev_q;
    logic [1:0]          speedPrev_q;

    logic [ANGLE_W-1:0]  manualTarget;
    logic [ANGLE_W-1:0]  incTheta, decTheta, nextTheta;
    logic [1:0]          speedSel;
    logic                modeChange, stepDue;
    logic [2:0]          fcEff;

    sw_sync #(.WIDTH(SW_WIDTH)) u_sw_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d_i   (iSW),
        .q_o   (swS)
    );

    assign unusedSwBits = ^swS[SPEED_LSB-1:MANUAL_MSB+1];

    assign speedSel     = swS[SPEED_MSB:SPEED_LSB];
    assign manualTarget = (swS[MANUAL_MSB:MANUAL_LSB] > MAX_IDX) ? MAX_IDX
                                                                 : swS[MANUAL_MSB:MANUAL_LSB];
    assign incTheta     = (theta_q == MAX_IDX) ? '0 : theta_q + 1'b1;
    assign decTheta     = (theta_q == '0) ? MAX_IDX : theta_q - 1'b1;

    // A mode or speed change restarts the divider, even on the same cycle as a sync.
    assign modeChange = (swS[AUTO_BIT] != autoPrev_q) || (speedSel != speedPrev_q);
    assign fcEff      = modeChange ? 3'd0 : fc_q;
    assign stepDue    = ({1'b0, fcEff} + 4'd1) == speed_period(speedSel);

    always_comb begin
        state_d    = state_q;
        lc_d       = lc_q;
        fc_d       = fcEff;
        lutAddr_d  = lutAddr_q;
        theta_d    = theta_q;
        missed_d   = missed_q;
        nextTheta  = theta_q;
        oCOEF_LOAD = 1'b0;
        oBUSY      = (state_q != RUN);

        if (iFRAME_SYNC && (state_q != RUN)) begin
            missed_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (iFRAME_SYNC) begin
                    fc_d = stepDue ? 3'd0 : fcEff + 3'd1;
                    if (!swS[AUTO_BIT]) begin
                        nextTheta = manualTarget;
                    end else if (stepDue) begin
                        nextTheta = swS[DIR_BIT] ? decTheta : incTheta;
                    end
                    if (nextTheta != theta_q) begin
                        lutAddr_d = nextTheta;
                        lc_d      = 3'd0;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                if (lc_q == LC_LAST) begin
                    state_d = LOAD;
                end else begin
                    lc_d = lc_q + 3'd1;
                end
            end
            LOAD: begin
                oCOEF_LOAD = 1'b1;
                theta_d    = lutAddr_q;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RUN;
            lc_q        <= 3'd0;
            fc_q        <= 3'd0;
            lutAddr_q   <= '0;
            theta_q     <= '0;
            missed_q    <= 1'b0;
            autoPrev_q  <= 1'b0;
            speedPrev_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            lc_q        <= lc_d;
            fc_q        <= fc_d;
            lutAddr_q   <= lutAddr_d;
            theta_q     <= theta_d;
            missed_q    <= missed_d;
            autoPrev_q  <= swS[AUTO_BIT];
            speedPrev_q <= speedSel;
        end
    end

    assign oLUT_ADDR = lutAddr_q;
    assign oTHETA    = theta_q;
    assign oMISSED   = missed_q;

endmodule

// File: tb/tb_rotation_sequencer.sv
// Scoreboard bench for rotation_sequencer: directed frame syncs push expected
// loads, a monitor pops and checks them whenever the coefficient strobe fires.
module tb_rotation_sequencer;

    localparam int L = 2;

    localparam logic [17:0] AUTO_INC_S2 = 18'h28000;
    localparam logic [17:0] AUTO_DEC_S0 = 18'h30000;
    localparam logic [17:0] AUTO_INC_S1 = 18'h24000;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [17:0] iSW = '0;
    logic        iFRAME_SYNC = 1'b0;

    logic [6:0]  oLUT_ADDR, oTHETA;
    logic        oCOEF_LOAD, oBUSY, oMISSED;
    logic [6:0]  lut100, theta100;
    logic        load100, busy100, missed100;

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [6:0]  curTheta = '0;

    typedef struct {
        logic [6:0] theta;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    rotation_sequencer #(.THETA_STEPS(128), .LUT_LATENCY(L)) u_dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .iSW         (iSW),
        .iFRAME_SYNC (iFRAME_SYNC),
        .oLUT_ADDR   (oLUT_ADDR),
        .oTHETA      (oTHETA),
        .oCOEF_LOAD  (oCOEF_LOAD),
        .oBUSY       (oBUSY),
        .oMISSED     (oMISSED)
    );

    rotation_sequencer #(.THETA_STEPS(100), .LUT_LATENCY(L)) u_dut100 (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .iSW         (iSW),
        .iFRAME_SYNC (iFRAME_SYNC),
        .oLUT_ADDR   (lut100),
        .oTHETA      (theta100),
        .oCOEF_LOAD  (load100),
        .oBUSY       (busy100),
        .oMISSED     (missed100)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected load.
    always @(negedge CLK) begin
        if (oCOEF_LOAD !== 1'b0) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_load: got strobe=%b addr=%0d, expected no strobe (cycle %0d)",
                         oCOEF_LOAD, oLUT_ADDR, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("load_addr", oLUT_ADDR, e.theta);
                checkOutput("load_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [17:0] sw, input bit change,
                                 input logic [6:0] expTheta, input bit extraSync);
        exp_t e;
        @(posedge CLK);
        #1 iSW = sw;
        repeat (3) @(posedge CLK);
        #1;
        if (change) begin
            e.theta = expTheta;
            e.cyc   = cyc + 1 + L;
            sbq.push_back(e);
        end
        iFRAME_SYNC = 1'b1;
        @(posedge CLK);
        #1 iFRAME_SYNC = extraSync;
        @(negedge CLK);
        checkOutput("busy_t1", {31'd0, oBUSY}, {31'd0, change});
        if (change) checkOutput("lut_addr_t1", oLUT_ADDR, expTheta);
        @(posedge CLK);
        #1 iFRAME_SYNC = 1'b0;
        repeat (L + 2) @(posedge CLK);
        if (change) curTheta = expTheta;
        @(negedge CLK);
        checkOutput("theta", oTHETA, curTheta);
        checkOutput("busy_idle", oBUSY, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_lut_addr", oLUT_ADDR, 0);
        checkOutput("rst_theta", oTHETA, 0);
        checkOutput("rst_coef_load", oCOEF_LOAD, 0);
        checkOutput("rst_busy", oBUSY, 0);
        checkOutput("rst_missed", oMISSED, 0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Manual mode: new angle, then same angle (no fetch), then clamp.
        applyStimulus(18'h00005, 1'b1, 7'd5, 1'b0);
        applyStimulus(18'h00005, 1'b0, 7'd5, 1'b0);
        applyStimulus(18'h0007F, 1'b1, 7'd127, 1'b0);
        checkOutput("clamp_theta100", theta100, 99);
        applyStimulus(18'h0007E, 1'b1, 7'd126, 1'b0);

        // Auto increment, period 4: steps 127, 0, 1 on every 4th sync.
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(AUTO_INC_S2, (i % 4) == 0, 7'((126 + i / 4) % 128), 1'b0);
        end

        // Auto decrement, period 1, wrapping below zero.
        applyStimulus(18'h00000, 1'b1, 7'd0, 1'b0);
        applyStimulus(AUTO_DEC_S0, 1'b1, 7'd127, 1'b0);
        applyStimulus(AUTO_DEC_S0, 1'b1, 7'd126, 1'b0);

        // Period 2 with a sync during FETCH: flagged, and the divider holds.
        applyStimulus(AUTO_INC_S1, 1'b0, 7'd126, 1'b0);
        applyStimulus(AUTO_INC_S1, 1'b1, 7'd127, 1'b0);
        checkOutput("missed_clear", oMISSED, 0);
        applyStimulus(AUTO_INC_S1, 1'b0, 7'd127, 1'b0);
        applyStimulus(AUTO_INC_S1, 1'b1, 7'd0, 1'b1);
        checkOutput("missed_set", oMISSED, 1);
        applyStimulus(AUTO_INC_S1, 1'b0, 7'd0, 1'b0);
        applyStimulus(AUTO_INC_S1, 1'b1, 7'd1, 1'b0);
        checkOutput("missed_sticky", oMISSED, 1);

        // Reset in the middle of FETCH: outputs clear, no strobe follows.
        @(posedge CLK);
        #1 iSW = 18'h0000A;
        repeat (3) @(posedge CLK);
        #1 iFRAME_SYNC = 1'b1;
        @(posedge CLK);
        #1 iFRAME_SYNC = 1'b0;
        @(negedge CLK);
        checkOutput("midfetch_busy", oBUSY, 1);
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        checkOutput("midrst_lut_addr", oLUT_ADDR, 0);
        checkOutput("midrst_theta", oTHETA, 0);
        checkOutput("midrst_coef_load", oCOEF_LOAD, 0);
        checkOutput("midrst_busy", oBUSY, 0);
        checkOutput("midrst_missed", oMISSED, 0);
        repeat (L + 3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        curTheta = 7'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("postrst_theta", oTHETA, 0);
        checkOutput("postrst_busy", oBUSY, 0);
        applyStimulus(18'h0000A, 1'b1, 7'd10, 1'b0);

        repeat (4) @(posedge CLK);
        checkOutput("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rotation_sequencer.md
# rotation_sequencer

Frame-synchronous controller for the pixel-mapping rotation datapath. It decides the rotation angle index, drives the sine/cosine lookup-table address, waits out the LUT read latency, then pulses a coefficient-load strobe. The rotation datapath latches its SIN/COS coefficients only on that strobe, so the angle never changes mid-frame. Angle selection is either manual (switch value) or automatic (stepping one index every N frames, either direction).

## Interface
- THETA_STEPS, 128: number of angle indices; index range 0..THETA_STEPS-1.
- LUT_LATENCY, 2: cycles from oLUT_ADDR change to valid LUT q (1..7).
- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- iSW  in  18  raw switches, asynchronous. Fields:
  - [17] auto mode.
  - [16] direction (0 = increment, 1 = decrement).
  - [15:14] speed select.
  - [6:0] manual angle.
- iFRAME_SYNC  in  1  one-cycle pulse at the last pixel of a frame, from the pixel counter.
- oLUT_ADDR  out  7  sin/cos LUT address.
- oTHETA  out  7  committed angle index, matching the currently loaded coefficients.
- oCOEF_LOAD  out  1  one-cycle strobe; datapath latches LUT q on this cycle.
- oBUSY  out  1  high in FETCH and LOAD.
- oMISSED  out  1  sticky flag: a frame sync arrived while busy.

## Operation
- iSW passes through a 2-flop synchronizer; all decisions use the synchronized copy (sw_s).
- Manual target: sw_s[6:0], clamped to THETA_STEPS-1 when larger.
- Frame divider:
  - 3-bit frame counter fc; period P = 1, 2, 4 or 8 for speed 0..3.
  - Increments on each serviced frame sync. When fc+1 == P: fc <= 0, "step due".
  - fc is cleared on any change of sw_s[17] or sw_s[15:14].
- States:
  - RUN (reset state): waits for iFRAME_SYNC, then computes next:
    - Manual mode: next = clamped manual target.
    - Auto mode with step due: next = oTHETA ±1 mod THETA_STEPS. Increment wraps THETA_STEPS-1 -> 0; decrement wraps 0 -> THETA_STEPS-1.
    - Auto mode, step not due: next = oTHETA.
    - If next == oTHETA: remain in RUN, no strobe.
    - Otherwise: oLUT_ADDR <= next, go to FETCH, latency counter lc <= 0.
  - FETCH: lc increments each cycle. When lc == LUT_LATENCY-1, go to LOAD.
  - LOAD: oCOEF_LOAD = 1, oTHETA <= oLUT_ADDR, then return to RUN.
- iFRAME_SYNC in FETCH or LOAD:
  - Ignored: no divider advance, no re-target.
  - Sets oMISSED, which stays set until reset.
- oLUT_ADDR holds its value outside FETCH, so the LUT q stays equal to the coefficients of oTHETA.
- Reset mid-FETCH/LOAD: immediate return to RUN; no strobe is issued; all outputs take their reset values.

## Timing
- Reset values: oLUT_ADDR=0, oTHETA=0, oCOEF_LOAD=0, oBUSY=0, oMISSED=0, fc=0, synchronizer flops 0.
- Frame sync sampled at edge t (RUN, change needed):
  - oLUT_ADDR = new from t+1, and oBUSY goes high at t+1.
  - oCOEF_LOAD high during cycle t+1+LUT_LATENCY; oTHETA updates at the end of that cycle.
  - oBUSY low from t+2+LUT_LATENCY.
- Switch change to effect: 2 cycles of synchronizer latency before it can influence the next frame sync.
- Back-to-back frame syncs at the minimum legal spacing (≥ LUT_LATENCY+2 cycles) are all serviced.

## Structure
- Shared package holds:
  - The state enum (RUN, FETCH, LOAD).
  - Switch field positions: AUTO_BIT=17, DIR_BIT=16, SPEED_MSB/LSB=15/14, MANUAL_MSB/LSB=6/0.
  - Speed-to-period decode.
- Sub-module: sw_sync, a parameterised-width 2-flop synchronizer with async active-low reset.
- FSM, frame divider and angle arithmetic live in rotation_sequencer.

## Test plan
- Reset, manual mode, sw=0x00005, one frame sync at cycle 10:
  - oLUT_ADDR=5 at cycle 11.
  - oCOEF_LOAD pulse at cycle 13 (LUT_LATENCY=2).
  - oTHETA=5 from cycle 14.
- Manual sw=5 with oTHETA already 5, frame sync -> oBUSY stays 0 and no oCOEF_LOAD.
- Manual sw[6:0]=127 with THETA_STEPS=100, frame sync -> oTHETA=99.
- Auto mode, increment, speed=2 (P=4), oTHETA=126, 12 frame syncs -> oTHETA steps 127, 0, 1, one load on every 4th sync.
- Auto mode, decrement, speed=0, oTHETA=0, frame sync -> oTHETA=127.
- Corner cases:
  - Frame sync asserted during FETCH -> oMISSED=1 and stays 1; the divider does not advance.
  - RESET_N low mid-FETCH -> all outputs 0, no strobe.
